// File: rtl/seg_scan_n.sv
// seg_scan_n - multiplexed seven-segment driver for DIGITS digits.
// A binary magnitude is converted to BCD by an iterative shift-add-3 FSM,
// formatted (leading-zero blanking, sign, overflow dashes, decimal points)
// into a display register, and scanned out one digit per slot with a
// 16-level brightness PWM. sel and seg are registered from the same state.
// Optional digit blinking (blink_mask input, BLINK_FRAMES parameter) is
// compiled in when the macro SEG_BLINK_EN is defined.
module seg_scan_n #(
  parameter int DIGITS      = 6,
  parameter int DATA_W      = 20,
  parameter int SCAN_DIV    = 50000,
  parameter int SEG_ACT_LOW = 1,
  parameter int SEL_ACT_LOW = 0
`ifdef SEG_BLINK_EN
  ,
  parameter int BLINK_FRAMES = 250
`endif
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              sign,
  input  logic [DIGITS-1:0] point,
  input  logic              load,
  input  logic              seg_en,
  input  logic [3:0]        bright,
`ifdef SEG_BLINK_EN
  input  logic [DIGITS-1:0] blink_mask,
`endif
  output logic              busy,
  output logic [DIGITS-1:0] sel,
  output logic [7:0]        seg
);

  // Enough BCD nibbles to hold 2^DATA_W-1 without loss (valid for DATA_W <= 27)
  localparam int BCD_N  = (DATA_W * 3) / 10 + 1;
  localparam int BCD_W  = BCD_N * 4;
  localparam int PAD_N  = (BCD_N > DIGITS) ? BCD_N : DIGITS;
  localparam int PAD_W  = PAD_N * 4;
  localparam int CNT_W  = $clog2(DATA_W + 1);
  localparam int PRE_W  = $clog2(SCAN_DIV);
  localparam int SLOT_W = $clog2(DIGITS);
  localparam int SUB    = SCAN_DIV / 16;

  // Internal codes are always held in active-low form
  localparam logic [7:0] CODE_DASH  = 8'hBF;
  localparam logic [7:0] CODE_BLANK = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_COMMIT
  } state_t;

  state_t              state_q, state_d;
  logic                busy_q, busy_d;
  logic [DATA_W-1:0]   bin_q, bin_d;
  logic [BCD_W-1:0]    bcd_q, bcd_d;
  logic [BCD_W-1:0]    bcd_adj;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                sign_q, sign_d;
  logic [DIGITS-1:0]   point_q, point_d;
  logic [DIGITS*8-1:0] disp_q, disp_d;

  logic [PAD_W-1:0]    bcd_pad;
  logic [DIGITS*8-1:0] fmt;
  logic                fmt_ovf;
  int                  fmt_h;

  logic [PRE_W-1:0]    presc_q, presc_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [DIGITS*8-1:0] show_q, show_d;
  logic [DIGITS-1:0]   sel_q, sel_d, sel_raw;
  logic [7:0]          seg_q, seg_d, seg_raw;
  logic                presc_wrap;
  logic                active;
  logic [31:0]         win_end;
  logic [7:0]          code_cur;

  function automatic logic [7:0] digit_code(input logic [3:0] d);
    case (d)
      4'd0:    digit_code = 8'hC0;
      4'd1:    digit_code = 8'hF9;
      4'd2:    digit_code = 8'hA4;
      4'd3:    digit_code = 8'hB0;
      4'd4:    digit_code = 8'h99;
      4'd5:    digit_code = 8'h92;
      4'd6:    digit_code = 8'h82;
      4'd7:    digit_code = 8'hF8;
      4'd8:    digit_code = 8'h80;
      4'd9:    digit_code = 8'h90;
      default: digit_code = CODE_BLANK;
    endcase
  endfunction

`ifdef SEG_BLINK_EN
  localparam int FR_W = $clog2(BLINK_FRAMES + 1);
  logic [FR_W-1:0] frame_cnt_q, frame_cnt_d;
  logic            blink_on_q, blink_on_d;

  // Count whole scan frames and flip the blink phase every BLINK_FRAMES of them
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    blink_on_d  = blink_on_q;
    if (presc_wrap && slot_q == SLOT_W'(DIGITS - 1)) begin
      if (frame_cnt_q == FR_W'(BLINK_FRAMES - 1)) begin
        frame_cnt_d = '0;
        blink_on_d  = ~blink_on_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end
  end

  // Blink phase registers; the phase starts in the "on" half after reset
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      frame_cnt_q <= '0;
      blink_on_q  <= 1'b1;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      blink_on_q  <= blink_on_d;
    end
  end
`endif

  // Turn the finished BCD plus sign/point into per-digit segment codes
  always_comb begin
    bcd_pad = PAD_W'(bcd_q);
    fmt_ovf = 1'b0;
    fmt_h   = 0;
    fmt     = {DIGITS{CODE_BLANK}};
    for (int n = DIGITS; n < PAD_N; n++) begin
      if (bcd_pad[n*4 +: 4] != 4'd0) fmt_ovf = 1'b1;
    end
    for (int n = 0; n < DIGITS; n++) begin
      if (bcd_pad[n*4 +: 4] != 4'd0 || point_q[n]) fmt_h = n;
    end
    if (sign_q && fmt_h == DIGITS - 1) fmt_ovf = 1'b1;
    for (int n = 0; n < DIGITS; n++) begin
      if (fmt_ovf) begin
        fmt[n*8 +: 8] = CODE_DASH;
      end else if (n <= fmt_h) begin
        fmt[n*8 +: 8] = digit_code(bcd_pad[n*4 +: 4]);
        if (point_q[n]) fmt[n*8 + 7] = 1'b0;
      end else if (sign_q && n == fmt_h + 1) begin
        fmt[n*8 +: 8] = CODE_DASH;
      end
    end
  end

  // Conversion FSM next state: capture on load, DATA_W shift-add-3 steps, commit
  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    sign_d  = sign_q;
    point_d = point_q;
    disp_d  = disp_q;
    bcd_adj = bcd_q;
    case (state_q)
      ST_IDLE: begin
        if (load) begin
          bin_d   = data_in;
          bcd_d   = '0;
          cnt_d   = '0;
          sign_d  = sign;
          point_d = point;
          busy_d  = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        for (int n = 0; n < BCD_N; n++) begin
          if (bcd_adj[n*4 +: 4] >= 4'd5) bcd_adj[n*4 +: 4] = bcd_adj[n*4 +: 4] + 4'd3;
        end
        bcd_d = {bcd_adj[BCD_W-2:0], bin_q[DATA_W-1]};
        bin_d = bin_q << 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(DATA_W - 1)) state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        disp_d  = fmt;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Conversion FSM registers; reset aborts any conversion and blanks the display
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
      point_q <= '0;
      disp_q  <= {DIGITS{CODE_BLANK}};
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
      point_q <= point_d;
      disp_q  <= disp_d;
    end
  end

  // Scan timing, slot-boundary display update and PWM-gated sel/seg values
  always_comb begin
    presc_wrap = (presc_q == PRE_W'(SCAN_DIV - 1));
    presc_d    = presc_wrap ? '0 : presc_q + 1'b1;
    slot_d     = slot_q;
    show_d     = show_q;
    if (presc_wrap) begin
      slot_d = (slot_q == SLOT_W'(DIGITS - 1)) ? '0 : slot_q + 1'b1;
      show_d = disp_q;
    end
    win_end  = (32'(bright) + 32'd1) * SUB;
    active   = seg_en && (32'(presc_q) < win_end);
    code_cur = show_q[slot_q*8 +: 8];
`ifdef SEG_BLINK_EN
    if (!blink_on_q && blink_mask[slot_q]) code_cur = CODE_BLANK;
`endif
    sel_raw = active ? (DIGITS'(1) << slot_q) : '0;
    seg_raw = active ? code_cur : CODE_BLANK;
    sel_d   = (SEL_ACT_LOW != 0) ? ~sel_raw : sel_raw;
    seg_d   = (SEG_ACT_LOW != 0) ? seg_raw : ~seg_raw;
  end

  // Scan registers; sel and seg update together so they never misalign
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      presc_q <= '0;
      slot_q  <= '0;
      show_q  <= {DIGITS{CODE_BLANK}};
      sel_q   <= (SEL_ACT_LOW != 0) ? '1 : '0;
      seg_q   <= (SEG_ACT_LOW != 0) ? 8'hFF : 8'h00;
    end else begin
      presc_q <= presc_d;
      slot_q  <= slot_d;
      show_q  <= show_d;
      sel_q   <= sel_d;
      seg_q   <= seg_d;
    end
  end

  assign busy = busy_q;
  assign sel  = sel_q;
  assign seg  = seg_q;

endmodule

// File: doc/seg_scan_n.md
Name: seg_scan_n

Overview:
- Parametrised multiplexed seven-segment driver for N digits.
- Accepts a binary value with sign and decimal-point mask on a load pulse.
- Converts the value to BCD with an iterative shift-add-3 FSM, applies leading-zero blanking, sign placement and overflow indication.
- Scans digits with registered, mutually aligned sel/seg and 16-level brightness PWM. Sits between result/status logic and board LED pins.

Parameters:
- DIGITS, 6, number of digits (2..8); digit 0 is least significant.
- DATA_W, 20, binary input width (1..27).
- SCAN_DIV, 50000, clocks per digit slot; must be a multiple of 16.
- SEG_ACT_LOW, 1, 1 = segments active-low, 0 = active-high.
- SEL_ACT_LOW, 0, 1 = digit selects active-low, 0 = active-high.

Ports:
- sys_clk  in  1  system clock
- sys_rst_n  in  1  asynchronous reset, active-low
- data_in  in  DATA_W  unsigned magnitude to display
- sign  in  1  1 = show minus sign
- point  in  DIGITS  decimal point per digit, 1 = lit
- load  in  1  single-cycle request to capture data_in/sign/point
- seg_en  in  1  1 = display on
- bright  in  4  brightness, 0 = dimmest, 15 = full
- busy  out  1  conversion in progress
- sel  out  DIGITS  one-hot digit select (polarity per SEL_ACT_LOW)
- seg  out  8  {dp, g, f, e, d, c, b, a} (polarity per SEG_ACT_LOW)

Behaviour:
- Reset values:
  - busy = 0; prescaler = 0; slot = 0.
  - Display register: all digits blank.
  - sel = all inactive level; seg = all-off level.
- Conversion FSM (IDLE -> SHIFT -> COMMIT -> IDLE):
  - load while in IDLE captures data_in, sign and point; busy = 1 from the next cycle.
  - SHIFT runs DATA_W iterations, one per clock: add 3 to every BCD nibble >= 5, then shift left one bit.
  - COMMIT writes the display register. busy is high for DATA_W+1 cycles and falls the cycle after COMMIT.
  - The new display register is visible on the next slot boundary.
  - load while busy is ignored; no queueing.
  - Reset mid-conversion aborts the conversion and the display returns to blank.
- Digit formatting:
  - h = max(index of the most significant nonzero BCD digit, index of the highest set point bit, 0).
  - Digits above h are blank; digit 0 always shows a number.
  - If sign = 1 and h < DIGITS-1, digit h+1 shows '-' (dp off).
  - Overflow (all digits show '-', dp off) when either:
    - the value is > 10^DIGITS - 1, or
    - sign = 1 and h = DIGITS-1.
  - A digit's dp follows point[i] whenever that digit shows a number.
- Segment codes, active-low form (inverted when SEG_ACT_LOW = 0):
  - 0:C0, 1:F9, 2:A4, 3:B0, 4:99, 5:92, 6:82, 7:F8, 8:80, 9:90
  - '-':BF, blank:FF
  - dp clears bit 7 of the code.
- Scan:
  - The prescaler counts 0..SCAN_DIV-1 and wraps.
  - On wrap, slot advances 0..DIGITS-1 and wraps to 0.
  - sel and seg are both registered from the same slot/prescaler state and change on the same clock edge.
- Brightness:
  - The slot is active while prescaler < (bright+1)*(SCAN_DIV/16).
  - Outside the active window, sel is all inactive and seg is all-off.
  - bright = 15 gives the full slot; bright may change at any time and takes effect next clock.
- seg_en = 0: sel inactive and seg off from the next clock. The scan and the FSM keep running.

Optional Feature:
- Macro SEG_BLINK_EN.
- When defined:
  - Adds input blink_mask [DIGITS] and parameter BLINK_FRAMES (default 250).
  - A blink phase bit toggles every BLINK_FRAMES full scan frames (a frame is DIGITS slots); reset phase = on.
  - During the off phase, digits with blink_mask[i] = 1 output blank (seg off; sel still driven per PWM).
- When undefined: no port, no counter, no blinking.

Test Plan (SCAN_DIV = 64, DIGITS = 6, DATA_W = 20 unless stated):
- load data=12345, sign=0, point=0, bright=15 -> busy high exactly 21 cycles; slots 0..5 show seg 92, 99, B0, A4, F9, FF.
- load data=7, sign=1 -> slot0 F8, slot1 BF, slots 2..5 FF.
- load data=0, point=000100b -> slots 0..2 show C0, C0, 40; slots 3..5 FF.
- load data=999999, sign=1 -> all slots BF. Separately, data=1000000 -> all slots BF.
- bright=3 -> sel active 16 of every 64 clocks per slot, seg FF otherwise. bright=15 -> active 64 of 64. seg_en=0 -> sel 000000, seg FF.
- Second load issued 5 cycles after the first -> ignored, display shows the first value. Reset asserted at cycle 10 of a conversion -> busy 0, all slots FF after release.
